// File: rtl/irq_pending_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_ctrl_pkg
//  Purpose  : Shared sizes and grant-FSM state encoding for irq_pending_ctrl.
//  Revision : 1.0
// ============================================================================
package irq_pending_ctrl_pkg;

    localparam int N_SRC = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage : irq_pending_ctrl_pkg
`default_nettype wire

// File: rtl/irq_pending_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_ctrl_if
//  Purpose  : Request lines, mask and grant handshake of the pending controller.
//  Revision : 1.0
// ============================================================================
interface irq_pending_ctrl_if;
    import irq_pending_ctrl_pkg::*;

    logic [N_SRC-1:0] irq_in;
    logic [N_SRC-1:0] mask;
    logic             irq_ack;
    logic             irq_valid;
    logic [IDX_W-1:0] irq_id;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] overrun;

    // Requesting/consuming side
    modport master (
        output irq_in, mask, irq_ack,
        input  irq_valid, irq_id, pending, overrun
    );

    // Controller side
    modport slave (
        input  irq_in, mask, irq_ack,
        output irq_valid, irq_id, pending, overrun
    );

endinterface : irq_pending_ctrl_if
`default_nettype wire

// File: rtl/irq_pending_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc
//  Purpose  : Combinational 8-to-3 encoder, highest set index wins, plus any flag.
//  Revision : 1.0
// ============================================================================
module prio_enc
    import irq_pending_ctrl_pkg::*;
(
    input  wire logic [N_SRC-1:0] cand,
    output logic      [IDX_W-1:0] id,
    output logic                  any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cand[i]) begin
                id  = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule : prio_enc
`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_ctrl
//  Purpose  : Sticky maskable interrupt pending bits with one-at-a-time grant.
//  Revision : 1.0
// ============================================================================
module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    irq_pending_ctrl_if.slave bus
);

    logic [N_SRC-1:0] irq_prev_q, irq_prev_d;
    logic [N_SRC-1:0] pending_q,  pending_d;
    logic [N_SRC-1:0] overrun_q,  overrun_d;
    logic [IDX_W-1:0] irq_id_q,   irq_id_d;
    state_t           state_q,    state_d;

    logic [N_SRC-1:0] w_event;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_cand;
    logic [IDX_W-1:0] w_win_id;
    logic             w_win_any;
    logic             w_grant;

    assign w_event = bus.irq_in & ~irq_prev_q;
    assign w_cand  = pending_q & bus.mask;
    assign w_grant = (state_q == ISSUE) && bus.irq_ack;

    prio_enc u_prio_enc (
        .cand (w_cand),
        .id   (w_win_id),
        .any  (w_win_any)
    );

    // A new event on the acked source keeps it pending but is not an overrun
    always_comb begin
        w_clr = '0;
        if (w_grant) begin
            w_clr[irq_id_q] = 1'b1;
        end
        irq_prev_d = bus.irq_in;
        pending_d  = w_event | (pending_q & ~w_clr);
        overrun_d  = (w_event & pending_q & ~w_clr) | (overrun_q & ~w_clr);
    end

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            IDLE: begin
                if (w_win_any) begin
                    irq_id_d = w_win_id;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.irq_ack) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            irq_id_q   <= '0;
            state_q    <= IDLE;
        end else begin
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            irq_id_q   <= irq_id_d;
            state_q    <= state_d;
        end
    end

    assign bus.irq_valid = (state_q == ISSUE);
    assign bus.irq_id    = irq_id_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;

endmodule : irq_pending_ctrl
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_pending_ctrl
//  Purpose  : Directed and random checks of irq_pending_ctrl against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_irq_pending_ctrl;
    import irq_pending_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    irq_pending_ctrl_if bus ();

    irq_pending_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: pending/overrun sets, plus "which grant is on offer"
    logic [7:0] m_prev, m_pend, m_ovr;
    int         m_phase;   // 0: nothing offered, 1: offering m_id, 2: one-cycle pause
    int         m_id;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_ovr   = '0;
        m_phase = 0;
        m_id    = 0;
    endtask

    task automatic model_edge(input logic [7:0] in, input logic [7:0] msk, input bit ack);
        logic [7:0] ev;
        logic [7:0] old_pend;
        logic [7:0] cand;
        bit         acked;
        bit         clr;
        ev       = in & ~m_prev;
        old_pend = m_pend;
        cand     = old_pend & msk;
        acked    = (m_phase == 1) && ack;
        for (int i = 0; i < 8; i++) begin
            clr = acked && (i == m_id);
            if (clr)                          m_ovr[i] = 1'b0;
            else if (ev[i] && old_pend[i])    m_ovr[i] = 1'b1;
            if (ev[i])                        m_pend[i] = 1'b1;
            else if (clr)                     m_pend[i] = 1'b0;
        end
        if (m_phase == 0) begin
            if (cand != 8'h00) begin
                for (int i = 7; i >= 0; i--) begin
                    if (cand[i]) begin
                        m_id = i;
                        break;
                    end
                end
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (ack) m_phase = 2;
        end else begin
            m_phase = 0;
        end
        m_prev = in;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"},   {7'b0, bus.irq_valid}, {7'b0, (m_phase == 1)});
        chk({tag, "_id"},      {5'b0, bus.irq_id},    8'(m_id));
        chk({tag, "_pending"}, bus.pending,           m_pend);
        chk({tag, "_overrun"}, bus.overrun,           m_ovr);
    endtask

    task automatic step(input logic [7:0] in, input logic [7:0] msk, input bit ack, input string tag);
        @(negedge clk);
        bus.irq_in  = in;
        bus.mask    = msk;
        bus.irq_ack = ack;
        @(posedge clk);
        model_edge(in, msk, ack);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] r_in;
        logic [7:0] r_msk;

        bus.irq_in  = '0;
        bus.mask    = 8'hFF;
        bus.irq_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single pulse on source 5
        step(8'h00, 8'hFF, 1'b0, "t1_idle");
        step(8'h20, 8'hFF, 1'b0, "t1_set");
        chk("t1_pend20", bus.pending, 8'h20);
        step(8'h00, 8'hFF, 1'b0, "t1_issue");
        chk("t1_id5", {5'b0, bus.irq_id}, 8'd5);
        step(8'h00, 8'hFF, 1'b1, "t1_ack");
        chk("t1_gap_valid", {7'b0, bus.irq_valid}, 8'h00);
        step(8'h00, 8'hFF, 1'b0, "t1_back");

        // Sources 1 and 6 together: 6 then 1
        step(8'h42, 8'hFF, 1'b0, "t2_set");
        step(8'h00, 8'hFF, 1'b0, "t2_iss6");
        chk("t2_id6", {5'b0, bus.irq_id}, 8'd6);
        step(8'h00, 8'hFF, 1'b1, "t2_ack6");
        step(8'h00, 8'hFF, 1'b0, "t2_idle");
        step(8'h00, 8'hFF, 1'b0, "t2_iss1");
        chk("t2_id1", {5'b0, bus.irq_id}, 8'd1);
        step(8'h00, 8'hFF, 1'b1, "t2_ack1");
        chk("t2_pend0", bus.pending, 8'h00);
        step(8'h00, 8'hFF, 1'b0, "t2_back");

        // Masked source 7 waits behind source 2
        step(8'h84, 8'h7F, 1'b0, "t3_set");
        step(8'h00, 8'h7F, 1'b0, "t3_iss2");
        chk("t3_id2", {5'b0, bus.irq_id}, 8'd2);
        step(8'h00, 8'h7F, 1'b1, "t3_ack2");
        step(8'h00, 8'h7F, 1'b0, "t3_idle");
        step(8'h00, 8'h7F, 1'b0, "t3_masked");
        chk("t3_pend80", bus.pending, 8'h80);
        step(8'h00, 8'hFF, 1'b0, "t3_iss7");
        chk("t3_id7", {5'b0, bus.irq_id}, 8'd7);
        step(8'h00, 8'hFF, 1'b1, "t3_ack7");
        step(8'h00, 8'hFF, 1'b0, "t3_back");

        // Overrun on source 3
        step(8'h08, 8'hFF, 1'b0, "t4_set");
        step(8'h00, 8'hFF, 1'b0, "t4_iss");
        step(8'h08, 8'hFF, 1'b0, "t4_again");
        chk("t4_ovr08", bus.overrun, 8'h08);
        step(8'h00, 8'hFF, 1'b1, "t4_ack");
        chk("t4_ovr0", bus.overrun, 8'h00);
        chk("t4_pend0", bus.pending, 8'h00);
        step(8'h00, 8'hFF, 1'b0, "t4_back");

        // Ack and new event on source 4 in the same cycle
        step(8'h10, 8'hFF, 1'b0, "t5_set");
        step(8'h00, 8'hFF, 1'b0, "t5_iss");
        step(8'h10, 8'hFF, 1'b1, "t5_ackset");
        chk("t5_pend10", bus.pending, 8'h10);
        chk("t5_ovr0", bus.overrun, 8'h00);
        step(8'h00, 8'hFF, 1'b0, "t5_idle");
        step(8'h00, 8'hFF, 1'b0, "t5_reiss");
        chk("t5_id4", {5'b0, bus.irq_id}, 8'd4);
        step(8'h00, 8'hFF, 1'b1, "t5_ack");
        step(8'h00, 8'hFF, 1'b0, "t5_back");

        // Reset while a grant is on offer
        step(8'h01, 8'hFF, 1'b0, "t6_set");
        step(8'h00, 8'hFF, 1'b0, "t6_iss");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 8'hFF, 1'b0, "t6_post1");
        step(8'h00, 8'hFF, 1'b0, "t6_post2");
        step(8'h00, 8'hFF, 1'b0, "t6_post3");

        // Random traffic
        r_in = 8'h00;
        for (int n = 0; n < 600; n++) begin
            r_in  = r_in ^ 8'($urandom & $urandom & $urandom);
            r_msk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            step(r_in, r_msk, bit'($urandom_range(0, 1)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_irq_pending_ctrl
`default_nettype wire
